// File: rtl/step_pkg.sv
// Shared types and constants for the front-panel step controller.
// Debouncer state encoding and synchronizer depth.
package step_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes one raw active-low key and qualifies it into
// a single-cycle press pulse.
module key_debouncer
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  key_state_t             state;
  key_state_t             state_nx;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Counter only advances below TC, so it can never wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!synced) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (synced) begin
          state_nx = RELEASED;
        end else if (cnt == TC) begin
          state_nx = PRESSED;
          press    = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (synced) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!synced) begin
          state_nx = PRESSED;
        end else if (cnt == TC) begin
          state_nx = RELEASED;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = RELEASED;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/step_controller.sv
// Front-panel step controller: debounced manual step, auto-run
// mode with a fixed divider, and a strobe counter.
module step_controller
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_step_n,
  input  logic       key_mode_n,
  output logic       step,
  output logic       running,
  output logic [7:0] step_count
);

  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(RUN_DIV - 1);

  logic          step_press;
  logic          mode_press;
  logic [DW-1:0] div;
  logic          div_tc;
  logic          step_nx;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_key (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_step_n),
    .press  (step_press)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_key (
    .clk    (clk),
    .reset_n(reset_n),
    .key_n  (key_mode_n),
    .press  (mode_press)
  );

  assign div_tc = running && (div == DIV_TC);

  // A mode toggle suppresses the divider strobe; a coincident
  // step press still counts if we were in manual mode.
  always_comb begin
    step_nx = 1'b0;
    if (mode_press) begin
      step_nx = step_press && !running;
    end else if (running) begin
      step_nx = div_tc;
    end else begin
      step_nx = step_press;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step       <= 1'b0;
      running    <= 1'b0;
      step_count <= '0;
      div        <= '0;
    end else begin
      step       <= step_nx;
      step_count <= step_count + {7'd0, step_nx};
      if (mode_press) begin
        running <= !running;
        div     <= '0;
      end else if (running) begin
        div <= div_tc ? '0 : div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller with DEBOUNCE_CYCLES=4,
// RUN_DIV=8: vector table, corner sequences and random keys.
module tb_step_controller;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_step_n = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       step;
  logic       running;
  logic [7:0] step_count;

  always #5 clk = ~clk;

  step_controller #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (R)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_step_n(key_step_n),
    .key_mode_n(key_mode_n),
    .step      (step),
    .running   (running),
    .step_count(step_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: synced level is the raw key two cycles late; a level
  // is accepted once the synced key has held it for D+1 cycles.
  bit pipe[2][2];
  bit prev[2];
  int runlen[2];
  bit deb[2];
  bit m_run;
  int m_t;
  int m_cnt;
  bit m_step;
  int seen;
  int st[$];

  typedef struct {
    int low;
    int exp_steps;
    int exp_lat;
  } vec_t;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] = 1'b1;
      pipe[i][1] = 1'b1;
      prev[i]    = 1'b1;
      runlen[i]  = 0;
      deb[i]     = 1'b1;
    end
    m_run  = 1'b0;
    m_t    = 0;
    m_cnt  = 0;
    m_step = 1'b0;
  endtask

  task automatic tick();
    bit raw[2];
    bit pr[2];
    bit syn;
    bit nxt;
    raw[0] = key_step_n;
    raw[1] = key_mode_n;
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        syn = pipe[i][1];
        runlen[i] = (syn == prev[i]) ? runlen[i] + 1 : 1;
        prev[i] = syn;
        pr[i] = 1'b0;
        if (syn != deb[i] && runlen[i] >= D + 1) begin
          deb[i] = syn;
          pr[i]  = !syn;
        end
      end
      if (pr[1])
        nxt = pr[0] && !m_run;
      else if (m_run)
        nxt = (m_t >= R) && (m_t % R == 0);
      else
        nxt = pr[0];
      if (pr[1]) begin
        m_run = !m_run;
        m_t   = 1;
      end else begin
        m_t++;
      end
      m_step = nxt;
      if (nxt) m_cnt = (m_cnt + 1) % 256;
      for (int i = 0; i < 2; i++) begin
        pipe[i][1] = pipe[i][0];
        pipe[i][0] = raw[i];
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    chk("step", int'(step), int'(m_step));
    chk("running", int'(running), int'(m_run));
    chk("step_count", int'(step_count), m_cnt);
    if (step) seen++;
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    vec_t vt[6];
    int lat;
    int rise;
    int hold[2];

    vt[0] = '{low: 1,  exp_steps: 0, exp_lat: 0};
    vt[1] = '{low: 3,  exp_steps: 0, exp_lat: 0};
    vt[2] = '{low: 4,  exp_steps: 0, exp_lat: 0};
    vt[3] = '{low: 5,  exp_steps: 1, exp_lat: D + 3};
    vt[4] = '{low: 6,  exp_steps: 1, exp_lat: D + 3};
    vt[5] = '{low: 20, exp_steps: 1, exp_lat: D + 3};

    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(4);

    // press-length table
    for (int v = 0; v < 6; v++) begin
      seen = 0;
      lat  = 0;
      key_step_n = 1'b0;
      for (int c = 1; c <= vt[v].low + 14; c++) begin
        if (c == vt[v].low + 1) key_step_n = 1'b1;
        tick();
        if (step && lat == 0) lat = c;
      end
      chk($sformatf("vec%0d_steps", v), seen, vt[v].exp_steps);
      chk($sformatf("vec%0d_latency", v), lat, vt[v].exp_lat);
    end

    // bounce on press and on release
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 32; c++) begin
      key_step_n = (c <= 12) ? (((c - 1) / 2) % 2 == 1) : 1'b0;
      tick();
      if (step && lat == 0) lat = c;
    end
    chk("bounce_steps", seen, 1);
    chk("bounce_latency", lat, 12 + D + 3);
    seen = 0;
    for (int c = 1; c <= 27; c++) begin
      key_step_n = (c <= 12) ? (((c - 1) / 2) % 2 == 0) : 1'b1;
      tick();
    end
    chk("release_bounce_steps", seen, 0);

    // run mode, ignored step press, toggle at terminal count
    rise = 0;
    st.delete();
    key_mode_n = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 9) key_mode_n = 1'b1;
      if (c == 10) key_step_n = 1'b0;
      if (c == 18) key_step_n = 1'b1;
      if (c == 41) key_mode_n = 1'b0;
      if (c == 54) key_mode_n = 1'b1;
      tick();
      if (running && rise == 0) rise = c;
      if (step) st.push_back(c);
      if (c == 47) begin
        chk("toggle_at_tc_running", int'(running), 0);
        chk("toggle_at_tc_step", int'(step), 0);
      end
    end
    chk("run_rise", rise, D + 3);
    chk("run_step_total", st.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("run_step%0d", i),
          (i < st.size()) ? st[i] : -1, D + 3 + R * (i + 1));

    // async reset mid-run with a step key mid-qualification
    key_mode_n = 1'b0;
    idle(8);
    key_mode_n = 1'b1;
    idle(10);
    key_step_n = 1'b0;
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_count", int'(step_count), 0);
    model_reset();
    idle(3);
    reset_n = 1'b1;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (step && lat == 0) lat = c;
    end
    chk("held_after_reset_latency", lat, D + 3);
    chk("held_after_reset_steps", seen, 1);
    key_step_n = 1'b1;
    idle(10);

    // 256 manual steps wrap the counter
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    seen = 0;
    for (int n = 0; n < 256; n++) begin
      key_step_n = 1'b0;
      idle(6);
      key_step_n = 1'b1;
      idle(7);
    end
    idle(4);
    chk("wrap_steps", seen, 256);
    chk("wrap_count", int'(step_count), 0);

    // random key activity against the reference
    hold[0] = 1;
    hold[1] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          hold[i] = int'($urandom_range(1, 14));
          if (i == 0)
            key_step_n = !key_step_n;
          else if ($urandom_range(0, 3) == 0)
            key_mode_n = !key_mode_n;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
